feature_frame_buffer: RTL and testbench

Ping-pong buffer that sits directly upstream of the logistic-regression classifier. It accepts one 30-word feature frame at a time over a valid/ready stream and holds each word as a 16-bit sign-magnitude value. It then presents each complete frame to the classifier as a randomly addressable bank. Because there are two banks, the next frame can be received while the classifier is still reading the current one.

---
 rtl/logreg_pkg.sv | 14 +
 rtl/feature_frame_buffer_if.sv | 23 ++
 rtl/feature_bank.sv | 33 +++
 rtl/feature_frame_buffer.sv | 124 ++++++++++++
 tb/tb_feature_frame_buffer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logreg_pkg.sv
// Shared definitions for the feature frame buffer and the logistic-regression classifier.
package logreg_pkg;
  localparam int N_FEAT = 30;
  localparam int FEAT_W = 16;
  localparam int AW     = 5;

  // Sign-magnitude feature word: bit FEAT_W-1 is the sign.
  typedef logic [FEAT_W-1:0] feat_t;

  typedef enum logic {
    FILL    = 1'b0,
    DISCARD = 1'b1
  } wr_state_e;
endpackage

// File: rtl/feature_frame_buffer_if.sv
// Stream-in and frame-read signals of the feature frame buffer.
interface feature_frame_buffer_if;
  logic                                s_valid;
  logic                                s_ready;
  logreg_pkg::feat_t                   s_data;
  logic                                s_last;
  logic                                frame_valid;
  logic                                frame_ack;
  logic [logreg_pkg::AW-1:0]           rd_addr;
  logreg_pkg::feat_t                   rd_data;
  logic [7:0]                          frame_cnt;
  logic                                err_len;

  modport slave (
    input  s_valid, s_data, s_last, frame_ack, rd_addr,
    output s_ready, frame_valid, rd_data, frame_cnt, err_len
  );

  modport master (
    output s_valid, s_data, s_last, frame_ack, rd_addr,
    input  s_ready, frame_valid, rd_data, frame_cnt, err_len
  );
endinterface

// File: rtl/feature_bank.sv
// One frame of feature storage: synchronous write, registered read; out-of-range reads return 0.
module feature_bank
  import logreg_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  feat_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output feat_t         rdata_o
);

  feat_t mem_q [N_FEAT];
  feat_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (raddr_i < AW'(N_FEAT)) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/feature_frame_buffer.sv
// Ping-pong feature frame buffer: fills one bank from a valid/ready stream while the
// classifier reads the other bank at random addresses.
module feature_frame_buffer
  import logreg_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  feature_frame_buffer_if.slave  bus
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N_FEAT - 1);

  wr_state_e     state_q, state_d;
  logic [1:0]    full_q, full_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          err_len_q, err_len_d;
  logic          rd_sel_rd_q;

  logic          s_ready;
  logic          frame_valid;
  logic          xfer;
  logic          ack;
  logic [1:0]    bank_we;
  feat_t         rdata0, rdata1;

  // Handshake outputs depend only on registered state.
  assign s_ready     = (state_q == FILL) ? !full_q[wr_sel_q] : 1'b1;
  assign frame_valid = full_q[rd_sel_q];
  assign xfer        = bus.s_valid && s_ready;
  assign ack         = bus.frame_ack && frame_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      full_q      <= 2'b00;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      wcnt_q      <= '0;
      frame_cnt_q <= 8'd0;
      err_len_q   <= 1'b0;
      rd_sel_rd_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      wcnt_q      <= wcnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_len_q   <= err_len_d;
      rd_sel_rd_q <= rd_sel_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    wcnt_d      = wcnt_q;
    frame_cnt_d = frame_cnt_q;
    err_len_d   = 1'b0;
    bank_we     = 2'b00;

    if (xfer) begin
      if (state_q == FILL) begin
        bank_we[wr_sel_q] = 1'b1;
        if (wcnt_q == LAST_IDX) begin
          // A frame that overruns is still delivered; its tail is dropped in DISCARD.
          full_d[wr_sel_q] = 1'b1;
          wr_sel_d         = !wr_sel_q;
          wcnt_d           = '0;
          frame_cnt_d      = frame_cnt_q + 8'd1;
          if (!bus.s_last) begin
            err_len_d = 1'b1;
            state_d   = DISCARD;
          end
        end else if (bus.s_last) begin
          err_len_d = 1'b1;
          wcnt_d    = '0;
        end else begin
          wcnt_d = wcnt_q + AW'(1);
        end
      end else if (bus.s_last) begin
        state_d = FILL;
      end
    end

    // A full bank cannot be written, so completion and ack never hit the same bank.
    if (ack) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
    end
  end

  feature_bank u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (bank_we[0]),
    .waddr_i (wcnt_q),
    .wdata_i (bus.s_data),
    .raddr_i (bus.rd_addr),
    .rdata_o (rdata0)
  );

  feature_bank u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (bank_we[1]),
    .waddr_i (wcnt_q),
    .wdata_i (bus.s_data),
    .raddr_i (bus.rd_addr),
    .rdata_o (rdata1)
  );

  assign bus.s_ready     = s_ready;
  assign bus.frame_valid = frame_valid;
  assign bus.rd_data     = rd_sel_rd_q ? rdata1 : rdata0;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.err_len     = err_len_q;

endmodule

// File: tb/tb_feature_frame_buffer.sv
// Randomized self-checking bench for feature_frame_buffer against a frame-level queue model.
module tb_feature_frame_buffer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  feature_frame_buffer_if ffb_if ();

  feature_frame_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ffb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: accepted words of the frame in progress and completed frames (30 words each).
  logic [15:0] m_cur[$];
  logic [15:0] m_done[$];
  bit          m_disc;
  int          m_cnt;

  function automatic void m_reset();
    m_cur.delete();
    m_done.delete();
    m_disc = 1'b0;
    m_cnt  = 0;
  endfunction

  function automatic logic m_push(input logic [15:0] d, input logic last);
    if (m_disc) begin
      if (last) m_disc = 1'b0;
      return 1'b0;
    end
    m_cur.push_back(d);
    if (m_cur.size() == 30) begin
      foreach (m_cur[i]) m_done.push_back(m_cur[i]);
      m_cur.delete();
      m_cnt++;
      if (!last) m_disc = 1'b1;
      return !last;
    end
    if (last) begin
      m_cur.delete();
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void m_ack();
    if (m_done.size() >= 30) for (int i = 0; i < 30; i++) void'(m_done.pop_front());
  endfunction

  function automatic logic m_ready();
    return m_disc || (m_done.size() < 60);
  endfunction

  // Stimulus primitives; every task starts and ends just after a falling edge.
  task automatic push(input logic [15:0] d, input logic last, output bit took, output logic err);
    int n;
    n = 0;
    ffb_if.s_valid = 1'b1;
    ffb_if.s_data  = d;
    ffb_if.s_last  = last;
    while (ffb_if.s_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    took = (ffb_if.s_ready === 1'b1);
    @(negedge clk);
    err = ffb_if.err_len;
    ffb_if.s_valid = 1'b0;
    ffb_if.s_last  = 1'b0;
  endtask

  task automatic rd(input int a, output logic [15:0] q);
    logic [4:0] a5;
    a5 = 5'(a);
    ffb_if.rd_addr = a5;
    @(negedge clk);
    q = ffb_if.rd_data;
  endtask

  task automatic do_ack();
    ffb_if.frame_ack = 1'b1;
    @(negedge clk);
    ffb_if.frame_ack = 1'b0;
    m_ack();
  endtask

  task automatic apply_reset();
    ffb_if.s_valid   = 1'b0;
    ffb_if.s_data    = '0;
    ffb_if.s_last    = 1'b0;
    ffb_if.frame_ack = 1'b0;
    ffb_if.rd_addr   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total += 5;
    if (ffb_if.s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%b exp=1", ffb_if.s_ready); end
    if (ffb_if.frame_valid !== 1'b0) begin bad++; $display("FAIL rst_frame_valid got=%b exp=0", ffb_if.frame_valid); end
    if (ffb_if.frame_cnt !== 8'd0) begin bad++; $display("FAIL rst_frame_cnt got=%0d exp=0", ffb_if.frame_cnt); end
    if (ffb_if.err_len !== 1'b0) begin bad++; $display("FAIL rst_err_len got=%b exp=0", ffb_if.err_len); end
    if (ffb_if.rd_data !== 16'h0000) begin bad++; $display("FAIL rst_rd_data got=%h exp=0000", ffb_if.rd_data); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (ffb_if.s_ready !== 1'b1) begin bad++; $display("FAIL post_rst_s_ready got=%b exp=1", ffb_if.s_ready); end
  endtask

  task automatic test_single();
    bit took; logic err; logic exp_err; logic [15:0] q;
    apply_reset();
    for (int i = 1; i <= 30; i++) begin
      exp_err = m_push(16'(i), i == 30);
      push(16'(i), i == 30, took, err);
      total++;
      if (!took || err !== exp_err) begin bad++; $display("FAIL single_word%0d took=%b err=%b exp_err=%b", i, took, err, exp_err); end
    end
    total += 2;
    if (ffb_if.frame_valid !== 1'b1) begin bad++; $display("FAIL single_frame_valid got=%b exp=1", ffb_if.frame_valid); end
    if (ffb_if.frame_cnt !== 8'd1) begin bad++; $display("FAIL single_frame_cnt got=%0d exp=1", ffb_if.frame_cnt); end
    rd(0, q);
    total++;
    if (q !== 16'h0001) begin bad++; $display("FAIL single_rd0 got=%h exp=0001", q); end
    rd(29, q);
    total++;
    if (q !== 16'h001E) begin bad++; $display("FAIL single_rd29 got=%h exp=001e", q); end
    for (int a = 30; a < 32; a++) begin
      rd(a, q);
      total++;
      if (q !== 16'h0000) begin bad++; $display("FAIL single_rd_oob%0d got=%h exp=0000", a, q); end
    end
    do_ack();
    total++;
    if (ffb_if.frame_valid !== 1'b0) begin bad++; $display("FAIL single_after_ack_valid got=%b exp=0", ffb_if.frame_valid); end
  endtask

  task automatic test_back_to_back();
    bit took; logic err; logic exp_err; logic [15:0] d; logic [15:0] q; logic [15:0] third[30];
    apply_reset();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 30; i++) begin
        d = 16'($urandom);
        exp_err = m_push(d, i == 29);
        push(d, i == 29, took, err);
        total++;
        if (!took || err !== exp_err) begin bad++; $display("FAIL b2b_f%0d_w%0d took=%b err=%b exp_err=%b", f, i, took, err, exp_err); end
      end
    end
    foreach (third[i]) third[i] = 16'($urandom);
    ffb_if.s_valid = 1'b1;
    ffb_if.s_data  = third[0];
    repeat (4) @(negedge clk);
    total += 3;
    if (ffb_if.s_ready !== m_ready()) begin bad++; $display("FAIL b2b_stall_ready got=%b exp=%b", ffb_if.s_ready, m_ready()); end
    if (ffb_if.frame_cnt !== 8'(m_cnt)) begin bad++; $display("FAIL b2b_stall_cnt got=%0d exp=%0d", ffb_if.frame_cnt, m_cnt); end
    if (ffb_if.frame_valid !== 1'b1) begin bad++; $display("FAIL b2b_stall_valid got=%b exp=1", ffb_if.frame_valid); end
    do_ack();
    total++;
    if (ffb_if.s_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_ack got=%b exp=1", ffb_if.s_ready); end
    for (int i = 0; i < 30; i++) begin
      exp_err = m_push(third[i], i == 29);
      push(third[i], i == 29, took, err);
      total++;
      if (!took || err !== exp_err) begin bad++; $display("FAIL b2b_third_w%0d took=%b err=%b", i, took, err); end
    end
    for (int f = 0; f < 2; f++) begin
      for (int a = 0; a < 30; a++) begin
        rd(a, q);
        total++;
        if (q !== m_done[a]) begin bad++; $display("FAIL b2b_read_f%0d_a%0d got=%h exp=%h", f, a, q, m_done[a]); end
      end
      do_ack();
    end
    total++;
    if (ffb_if.frame_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained_valid got=%b exp=0", ffb_if.frame_valid); end
  endtask

  task automatic test_short_frame();
    bit took; logic err; logic exp_err; logic [15:0] d; logic [15:0] q;
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      d = 16'($urandom);
      exp_err = m_push(d, i == 10);
      push(d, i == 10, took, err);
      total++;
      if (!took || err !== exp_err) begin bad++; $display("FAIL short_w%0d took=%b err=%b exp_err=%b", i, took, err, exp_err); end
    end
    @(negedge clk);
    total += 3;
    if (ffb_if.err_len !== 1'b0) begin bad++; $display("FAIL short_err_one_cycle got=%b exp=0", ffb_if.err_len); end
    if (ffb_if.frame_valid !== 1'b0) begin bad++; $display("FAIL short_frame_valid got=%b exp=0", ffb_if.frame_valid); end
    if (ffb_if.frame_cnt !== 8'd0) begin bad++; $display("FAIL short_frame_cnt got=%0d exp=0", ffb_if.frame_cnt); end
    for (int i = 0; i < 30; i++) begin
      d = 16'($urandom);
      exp_err = m_push(d, i == 29);
      push(d, i == 29, took, err);
      total++;
      if (!took || err !== exp_err) begin bad++; $display("FAIL short_next_w%0d took=%b err=%b", i, took, err); end
    end
    for (int a = 0; a < 30; a++) begin
      rd(a, q);
      total++;
      if (q !== m_done[a]) begin bad++; $display("FAIL short_next_rd%0d got=%h exp=%h", a, q, m_done[a]); end
    end
    do_ack();
  endtask

  task automatic test_long_frame();
    bit took; logic err; logic exp_err; logic [15:0] d; logic [15:0] q;
    apply_reset();
    for (int i = 1; i <= 33; i++) begin
      d = 16'($urandom);
      exp_err = m_push(d, i == 33);
      push(d, i == 33, took, err);
      total++;
      if (!took || err !== exp_err) begin bad++; $display("FAIL long_w%0d took=%b err=%b exp_err=%b", i, took, err, exp_err); end
    end
    total += 2;
    if (ffb_if.frame_valid !== 1'b1) begin bad++; $display("FAIL long_frame_valid got=%b exp=1", ffb_if.frame_valid); end
    if (ffb_if.frame_cnt !== 8'd1) begin bad++; $display("FAIL long_frame_cnt got=%0d exp=1", ffb_if.frame_cnt); end
    for (int a = 0; a < 30; a++) begin
      rd(a, q);
      total++;
      if (q !== m_done[a]) begin bad++; $display("FAIL long_rd%0d got=%h exp=%h", a, q, m_done[a]); end
    end
    for (int i = 0; i < 30; i++) begin
      d = 16'($urandom);
      exp_err = m_push(d, i == 29);
      push(d, i == 29, took, err);
    end
    total++;
    if (ffb_if.frame_cnt !== 8'(m_cnt)) begin bad++; $display("FAIL long_refill_cnt got=%0d exp=%0d", ffb_if.frame_cnt, m_cnt); end
    do_ack();
    for (int a = 0; a < 30; a++) begin
      rd(a, q);
      total++;
      if (q !== m_done[a]) begin bad++; $display("FAIL long_refill_rd%0d got=%h exp=%h", a, q, m_done[a]); end
    end
    do_ack();
  endtask

  task automatic test_ack_overlap();
    bit took; logic err; logic exp_err; logic [15:0] d; logic [15:0] q;
    apply_reset();
    for (int i = 0; i < 59; i++) begin
      d = 16'($urandom);
      exp_err = m_push(d, i == 29);
      push(d, i == 29, took, err);
    end
    d = 16'($urandom);
    ffb_if.s_valid   = 1'b1;
    ffb_if.s_data    = d;
    ffb_if.s_last    = 1'b1;
    ffb_if.frame_ack = 1'b1;
    total++;
    if (ffb_if.frame_valid !== 1'b1) begin bad++; $display("FAIL overlap_valid_before got=%b exp=1", ffb_if.frame_valid); end
    @(negedge clk);
    ffb_if.s_valid   = 1'b0;
    ffb_if.s_last    = 1'b0;
    ffb_if.frame_ack = 1'b0;
    exp_err = m_push(d, 1'b1);
    m_ack();
    total += 3;
    if (ffb_if.frame_valid !== 1'b1) begin bad++; $display("FAIL overlap_valid_after got=%b exp=1", ffb_if.frame_valid); end
    if (ffb_if.frame_cnt !== 8'(m_cnt)) begin bad++; $display("FAIL overlap_cnt got=%0d exp=%0d", ffb_if.frame_cnt, m_cnt); end
    if (ffb_if.err_len !== exp_err) begin bad++; $display("FAIL overlap_err got=%b exp=%b", ffb_if.err_len, exp_err); end
    for (int a = 0; a < 30; a++) begin
      rd(a, q);
      total++;
      if (q !== m_done[a]) begin bad++; $display("FAIL overlap_rd%0d got=%h exp=%h", a, q, m_done[a]); end
    end
    do_ack();
    total++;
    if (ffb_if.frame_valid !== 1'b0) begin bad++; $display("FAIL overlap_drained got=%b exp=0", ffb_if.frame_valid); end
  endtask

  task automatic test_reset_mid_frame();
    bit took; logic err; logic exp_err; logic [15:0] d; logic [15:0] q;
    apply_reset();
    for (int i = 0; i < 45; i++) begin
      d = 16'($urandom);
      exp_err = m_push(d, i == 29);
      push(d, i == 29, took, err);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total += 3;
    if (ffb_if.frame_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", ffb_if.frame_valid); end
    if (ffb_if.frame_cnt !== 8'd0) begin bad++; $display("FAIL midrst_cnt got=%0d exp=0", ffb_if.frame_cnt); end
    if (ffb_if.s_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", ffb_if.s_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    m_reset();
    for (int i = 0; i < 30; i++) begin
      d = 16'($urandom);
      exp_err = m_push(d, i == 29);
      push(d, i == 29, took, err);
      total++;
      if (!took || err !== exp_err) begin bad++; $display("FAIL midrst_w%0d took=%b err=%b", i, took, err); end
    end
    total++;
    if (ffb_if.frame_cnt !== 8'd1) begin bad++; $display("FAIL midrst_new_cnt got=%0d exp=1", ffb_if.frame_cnt); end
    for (int a = 0; a < 30; a++) begin
      rd(a, q);
      total++;
      if (q !== m_done[a]) begin bad++; $display("FAIL midrst_rd%0d got=%h exp=%h", a, q, m_done[a]); end
    end
    do_ack();
  endtask

  task automatic test_random();
    bit took; logic err; logic exp_err; logic [15:0] d; logic [15:0] q; int len;
    apply_reset();
    for (int f = 0; f < 12; f++) begin
      if (m_done.size() >= 60) begin
        for (int a = 0; a < 30; a++) begin
          rd(a, q);
          total++;
          if (q !== m_done[a]) begin bad++; $display("FAIL rand_f%0d_rd%0d got=%h exp=%h", f, a, q, m_done[a]); end
        end
        do_ack();
      end
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 30;
      for (int i = 1; i <= len; i++) begin
        d = 16'($urandom);
        exp_err = m_push(d, i == len);
        push(d, i == len, took, err);
        total++;
        if (!took || err !== exp_err) begin bad++; $display("FAIL rand_f%0d_w%0d took=%b err=%b exp_err=%b", f, i, took, err, exp_err); end
      end
      total += 3;
      if (ffb_if.frame_cnt !== 8'(m_cnt)) begin bad++; $display("FAIL rand_f%0d_cnt got=%0d exp=%0d", f, ffb_if.frame_cnt, m_cnt); end
      if (ffb_if.frame_valid !== (m_done.size() != 0)) begin bad++; $display("FAIL rand_f%0d_valid got=%b exp=%b", f, ffb_if.frame_valid, m_done.size() != 0); end
      if (ffb_if.s_ready !== m_ready()) begin bad++; $display("FAIL rand_f%0d_ready got=%b exp=%b", f, ffb_if.s_ready, m_ready()); end
    end
    while (m_done.size() >= 30) begin
      for (int a = 0; a < 30; a++) begin
        rd(a, q);
        total++;
        if (q !== m_done[a]) begin bad++; $display("FAIL rand_drain_rd%0d got=%h exp=%h", a, q, m_done[a]); end
      end
      do_ack();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_short_frame();
    test_long_frame();
    test_ack_overlap();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
